// File: rtl/config_chain_loader_if.sv
// Host-side word port of the configuration-chain loader.
// A word transfers on each rising edge where word_valid and word_ready are both high.
// The host holds word_in steady while word_valid is high and keeps it there until that edge.
// word_ready never depends on word_valid in the same cycle.
interface config_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Writer end of the LUT configuration chain: serialises host words onto config_in/config_en,
// then recirculates the chain once and compares readback CRC against the loaded CRC.
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int VERIFY_EN = 1
) (
  input  logic                  config_clk,
  input  logic                  config_rst,
  input  logic                  start,
  config_chain_loader_if.slave  host,
  output logic                  config_in,
  output logic                  config_en,
  input  logic                  config_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           crc_out,
  output logic [1:0]            state_dbg
);

  localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BW     = $clog2(CHAIN_LEN + 1);
  localparam int WW     = $clog2(NWORDS + 1);
  localparam int SW     = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [SW-1:0]     sbits;
  logic [BW-1:0]     bit_cnt;
  logic [WW-1:0]     word_cnt;
  logic [15:0]       crc_ld;
  logic [15:0]       crc_rb;

  logic load_shift;
  logic accept;
  logic last_bit;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // A new word is taken while the last bit of the current one shifts, so loads run without bubbles.
  assign host.word_ready = (state == LOAD) && (sbits <= SW'(1)) && (word_cnt < WW'(NWORDS));
  assign accept          = host.word_valid && host.word_ready;
  assign load_shift      = (state == LOAD) && (sbits != '0);
  assign last_bit        = (bit_cnt == BW'(CHAIN_LEN - 1));

  // In VERIFY the tail feeds straight back into the head, keeping the loop exactly CHAIN_LEN long.
  assign config_en = load_shift || (state == VERIFY);
  assign config_in = (state == VERIFY) ? config_out : (load_shift && sreg[0]);
  assign state_dbg = state;

  always_ff @(posedge config_clk) begin
    if (config_rst) begin
      state    <= IDLE;
      sreg     <= '0;
      sbits    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      crc_ld   <= '0;
      crc_rb   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      crc_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            sbits    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc_ld   <= 16'hFFFF;
            crc_rb   <= 16'hFFFF;
            error    <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + 1'b1;
          end
          if (load_shift) begin
            crc_ld  <= crc_step(crc_ld, sreg[0]);
            bit_cnt <= bit_cnt + 1'b1;
            sreg    <= sreg >> 1;
            sbits   <= sbits - 1'b1;
          end
          if (accept) begin
            sreg  <= host.word_in;
            sbits <= SW'(WORD_W);
          end
          // Upper bits of a partial final word are dropped here and never reach the chain.
          if (load_shift && last_bit) begin
            sbits <= '0;
            if (VERIFY_EN != 0) begin
              state   <= VERIFY;
              bit_cnt <= '0;
            end else begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              error   <= 1'b0;
              crc_out <= crc_step(crc_ld, sreg[0]);
            end
          end
        end
        VERIFY: begin
          crc_rb  <= crc_step(crc_rb, config_out);
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            error   <= (crc_step(crc_rb, config_out) != crc_ld);
            crc_out <= crc_ld;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Configuration-chain driver for the LUT fabric. It accepts configuration words from a host over a valid/ready handshake and serialises them onto the `config_in` / `config_en` shift chain formed by daisy-chained LUT / LUT6_2 cells. It observes the chain tail (`config_out`) to run a recirculating CRC readback check. This block is the writer end of the config chain; the LUT cells are the receivers.

## Interface
- `CHAIN_LEN`, default 64: total bits in the attached chain (64 = one LUT6_2); must be ≥ 2.
- `WORD_W`, default 8: host word width; must be ≥ 2.
- `VERIFY_EN`, default 1: 1 = run readback after the load; 0 = skip it.
- `config_clk`, in, 1: the single clock. The block and the chain both use it.
- `config_rst`, in, 1: synchronous reset, active-high.
- `start`, in, 1: single-cycle request to begin a load. Sampled only in IDLE.
- `word_in`, in, `WORD_W`: configuration word; bit 0 is shifted first.
- `word_valid`, in, 1: `word_in` is valid.
- `word_ready`, out, 1: block accepts `word_in` this cycle.
- `config_in`, out, 1: serial data to the chain head.
- `config_en`, out, 1: chain shift enable; the chain shifts one bit on each edge where this is high.
- `config_out`, in, 1: serial data from the chain tail.
- `busy`, out, 1: high in LOAD and VERIFY.
- `done`, out, 1: one-cycle pulse at the end of an operation.
- `error`, out, 1: readback CRC mismatch. Valid from `done`; held until the next accepted `start`.
- `crc_out`, out, 16: CRC of the loaded bitstream. Valid from `done`.

## Operation
- **States:** IDLE, LOAD, VERIFY, DONE.
- **IDLE → LOAD** on `start`.
  - Clears the bit counter and word counter.
  - Sets `crc_ld` = `crc_rb` = 0xFFFF.
  - Clears `error`.
- **LOAD**
  - Shift register `sreg` (`WORD_W` bits) with fill count `sbits`.
  - `word_ready` = LOAD && `sbits` ≤ 1 && words_accepted < ceil(`CHAIN_LEN`/`WORD_W`).
  - On handshake (`word_valid` && `word_ready`): `sreg` ← `word_in`, `sbits` ← `WORD_W`. A word accepted while the last bit is shifting replaces it after that shift, so there is no bubble.
  - `config_en` = LOAD && `sbits` > 0; `config_in` = `sreg[0]`.
  - Each shift: `sreg` shifts right, `sbits`−1, bit counter +1, `crc_ld` updated with the shifted bit.
  - When the bit counter reaches `CHAIN_LEN`, `sbits` is forced to 0. The unused upper bits of the final word are discarded and never driven.
  - With no word available, `config_en` is low and the chain holds.
- **LOAD exit** when the bit counter = `CHAIN_LEN`: go to VERIFY if `VERIFY_EN`, else DONE.
- **VERIFY** (exactly `CHAIN_LEN` cycles)
  - `config_en` = 1; `config_in` = `config_out`, so the chain recirculates and ends with its contents unchanged.
  - `crc_rb` is updated with `config_out` each cycle.
- **DONE** (one cycle)
  - `done` = 1; `error` ← (`VERIFY_EN` && `crc_rb` ≠ `crc_ld`); `crc_out` ← `crc_ld`.
  - Next state is IDLE.
- **CRC:** CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial. Each cycle: fb = crc[15] ^ bit; crc = {crc[14:0],0} ^ (fb ? 0x1021 : 0). No final XOR.
- **Ignored inputs**
  - `start` outside IDLE has no effect.
  - `word_valid` outside LOAD is ignored; `word_ready` is 0 there.
- **Reset at any time:** state → IDLE; all counters cleared; `crc_out` = 0. The chain contents are left undefined (a partial load). The next `start` must reload.

## Timing
- **Reset values:** `word_ready`=0, `config_en`=0, `config_in`=0, `busy`=0, `done`=0, `error`=0, `crc_out`=0.
- **Combinational outputs**
  - `config_en`, `config_in` and `word_ready` are combinational from registered state only.
  - The one exception is the `config_out`→`config_in` path in VERIFY. It is combinational so the recirculating loop stays exactly `CHAIN_LEN` long.
  - There is no combinational path from `word_valid` or `start` to any output.
- **Cycle sequence**
  - `start` sampled at cycle 0 → LOAD at cycle 1, `word_ready`=1.
  - A word accepted at cycle t gives its first `config_en` at cycle t+1.
  - Back-to-back words give continuous `config_en` for `CHAIN_LEN` cycles.
- **Example, defaults, no stalls**
  - Accept at cycle 1.
  - Shifts at cycles 2..65.
  - VERIFY at cycles 66..129.
  - `done` at cycle 130; `busy` low at 130.
  - IDLE at 131; a new `start` is accepted at cycle 131.

## Test plan
- **Reset:** hold `config_rst` 2 cycles with random inputs → all outputs at reset values; `start` one cycle after release enters LOAD.
- **Back-to-back load,** defaults, words 0x01..0x08 presented continuously:
  - `config_en` high cycles 2..65.
  - `config_in` stream matches words LSB-first.
  - Behavioural 64-bit chain model contents equal the stream.
  - `done` at 130, `error`=0, `crc_out` = reference CRC.
- **Stalls:** `word_valid` dropped for 3 cycles between each word → `config_en` low during the gaps, exactly 64 enabled LOAD cycles, identical chain contents and `crc_out`.
- **Fault injection:** chain model inverts the tail bit once during VERIFY → `error`=1 at `done`, held until the next `start`, cleared on that `start`.
- **Odd length:** `CHAIN_LEN`=20, `WORD_W`=8, words 0xA5, 0x3C, 0xFF → exactly 3 words accepted, 20 shifts, final word's bits [7:4] never driven; `VERIFY_EN`=0 gives `done` the cycle after the last shift.
- **Mid-operation:**
  - `start` pulsed during LOAD → ignored.
  - `config_rst` after 3 accepted words → next cycle `busy`=0, `config_en`=0, `word_ready`=0.
  - A fresh full load afterwards passes with `error`=0.
